// File: rtl/buzzer_scheduler_pkg.sv
// Shared types and constants for the buzzer scheduler: FSM states, requester indices, widths.
package buzzer_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff,
    StGap
  } state_e;

  localparam int unsigned NumReq = 3;
  localparam logic [1:0]  ReqSos = 2'd0;
  localparam logic [1:0]  ReqKey = 2'd1;
  localparam logic [1:0]  ReqAlm = 2'd2;

  localparam int unsigned SubW  = 16;
  localparam int unsigned MsW   = 10;
  localparam int unsigned BeepW = 4;

  function automatic logic [NumReq-1:0] idx_to_onehot(input logic [1:0] idx);
    return NumReq'(1) << idx;
  endfunction

endpackage

// File: rtl/buzzer_scheduler_if.sv
// Request/grant/status bundle between the beep sources and the buzzer scheduler.
interface buzzer_scheduler_if;
  import buzzer_scheduler_pkg::*;

  logic [NumReq-1:0] req;
  logic [NumReq-1:0] grant;
  logic              busy;
  logic              done;
  logic              pin;

  modport master (output req, input grant, busy, done, pin);
  modport slave  (input req, output grant, busy, done, pin);
endinterface

// File: rtl/buzzer_scheduler_phase_timer.sv
// Millisecond phase timer: restarts on start, pulses expire on the last cycle of dur_ms.
module buzzer_scheduler_phase_timer
  import buzzer_scheduler_pkg::*;
#(
  parameter int unsigned ClkPerMs = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [MsW-1:0] dur_ms,
  output logic           expire
);

  localparam logic [SubW-1:0] SubLast = SubW'(ClkPerMs - 1);

  logic [SubW-1:0] sub_q;
  logic [MsW-1:0]  ms_q;
  logic [MsW-1:0]  dur_q;
  logic            run_q;

  assign expire = run_q && (sub_q == SubLast) && (ms_q == dur_q - MsW'(1));

  // Counters hold once the phase has expired, so they never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= '0;
      ms_q  <= '0;
      dur_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sub_q <= '0;
      ms_q  <= '0;
      dur_q <= dur_ms;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (expire) begin
        run_q <= 1'b0;
      end else if (sub_q == SubLast) begin
        sub_q <= '0;
        ms_q  <= ms_q + MsW'(1);
      end else begin
        sub_q <= sub_q + SubW'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_scheduler.sv
// Shares one active-low buzzer among SOS, key-click and alarm sources by fixed priority.
module buzzer_scheduler
  import buzzer_scheduler_pkg::*;
#(
  parameter int unsigned ClkPerMs = 50000,
  parameter int unsigned SosN     = 3,
  parameter int unsigned SosOnMs  = 100,
  parameter int unsigned SosOffMs = 100,
  parameter int unsigned KeyN     = 1,
  parameter int unsigned KeyOnMs  = 50,
  parameter int unsigned KeyOffMs = 0,
  parameter int unsigned AlmN     = 5,
  parameter int unsigned AlmOnMs  = 500,
  parameter int unsigned AlmOffMs = 500,
  parameter int unsigned GapMs    = 200
) (
  input logic                clk,
  input logic                rst_n,
  buzzer_scheduler_if.slave  bus
);

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [BeepW-1:0]   beep_q, beep_d;
  logic [NumReq-1:0]  pend_q, pend_d;
  logic [1:0]         pick, sel;
  logic [BeepW-1:0]   pat_n;
  logic [MsW-1:0]     pat_on, pat_off;
  logic               start, expire;
  logic [MsW-1:0]     dur;

  assign pick = pend_q[ReqSos] ? ReqSos : (pend_q[ReqKey] ? ReqKey : ReqAlm);
  // In IDLE the pattern being launched is the pick; afterwards it is the owner's.
  assign sel  = (state_q == StIdle) ? pick : owner_q;

  always_comb begin
    pat_n   = BeepW'(SosN);
    pat_on  = MsW'(SosOnMs);
    pat_off = MsW'(SosOffMs);
    unique case (sel)
      ReqKey: begin
        pat_n   = BeepW'(KeyN);
        pat_on  = MsW'(KeyOnMs);
        pat_off = MsW'(KeyOffMs);
      end
      ReqAlm: begin
        pat_n   = BeepW'(AlmN);
        pat_on  = MsW'(AlmOnMs);
        pat_off = MsW'(AlmOffMs);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beep_d  = beep_q;
    pend_d  = pend_q | bus.req;
    start   = 1'b0;
    dur     = '0;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          owner_d = pick;
          beep_d  = '0;
          state_d = StOn;
          start   = 1'b1;
          dur     = pat_on;
          pend_d  = (pend_q & ~idx_to_onehot(pick)) | bus.req;
        end
      end
      StOn: begin
        if (expire) begin
          beep_d = beep_q + BeepW'(1);
          start  = 1'b1;
          if (beep_d == pat_n) begin
            state_d = StGap;
            dur     = MsW'(GapMs);
          end else if (pat_off != '0) begin
            state_d = StOff;
            dur     = pat_off;
          end else begin
            dur     = pat_on;
          end
        end
      end
      StOff: begin
        if (expire) begin
          state_d = StOn;
          start   = 1'b1;
          dur     = pat_on;
        end
      end
      StGap: begin
        if (expire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      beep_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beep_q  <= beep_d;
      pend_q  <= pend_d;
    end
  end

  buzzer_scheduler_phase_timer #(
    .ClkPerMs (ClkPerMs)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .dur_ms (dur),
    .expire (expire)
  );

  // Outputs decode registered state only, so reset silences the pin at once.
  assign bus.grant = (state_q == StIdle) ? '0 : idx_to_onehot(owner_q);
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StGap) && expire;
  assign bus.pin   = (state_q != StOn);

endmodule
